// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V main controller and the
// downstream ALU-control decoder: FSM states, opcodes, ALUOp codes,
// datapath mux-select codes and immediate-format codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format per opcode; anything without an immediate of its own
  // (R-type, unknown) falls back to the I format.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] r;
    r = IMM_I;
    case (op)
      OP_SW:   r = IMM_S;
      OP_BEQ:  r = IMM_B;
      OP_JAL:  r = IMM_J;
      default: r = IMM_I;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/main_control_fsm_imm_src_decode.sv
// imm_src_decode: combinational opcode -> immediate-format select.
//  i_opcode  in  7  instr[6:0]
//  o_imm_src out 2  00 I, 01 S, 10 B, 11 J
module imm_src_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [1:0] o_imm_src
);
  assign o_imm_src = imm_src_of(i_opcode);
endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle RISC-V main controller (Moore FSM) for
// lw, sw, R-type, I-type ALU, beq and jal, with a retired-instruction counter.
//  clk, reset        clock and synchronous active-high reset
//  opcode, zero      IR opcode and ALU zero flag
//  mem_ready         memory access completes this cycle
//  pc_write..mem_write  datapath enables (all forced low while reset is high)
//  adr_src, result_src, alu_src_a, alu_src_b  datapath mux selects
//  alu_op, fun7_en   ALU-control decoder inputs
//  imm_src           immediate format (combinational from opcode)
//  illegal           sticky unknown-opcode flag
//  instret           retired instruction count, wraps
module main_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             adr_src,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             fun7_en,
  output logic [1:0]       imm_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_e           r_state;
  state_e           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_instret;
  logic             r_illegal;

  logic w_pc_update, w_branch, w_ir_write, w_reg_write, w_mem_write;

  imm_src_decode u_imm (
    .i_opcode  (opcode),
    .o_imm_src (imm_src)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_FETCH;
    endcase
  end

  // Retire on the last state of every instruction; a stalled FETCH
  // looping on itself is not a retire.
  always_comb begin
    w_retire = 1'b0;
    if (w_next == S_FETCH) begin
      case (r_state)
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: w_retire = 1'b1;
        default:                             w_retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire)              r_instret <= r_instret + 1'b1;
      // Flag is raised on entry so it is already visible in ILLEGAL.
      if (w_next == S_ILLEGAL)   r_illegal <= 1'b1;
    end
  end

  // Moore decode from state; FETCH's IR/PC update is qualified by mem_ready
  // so a stalled fetch leaves PC and IR untouched.
  always_comb begin
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_write = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    fun7_en     = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_FOUR;
        alu_op      = ALUOP_ADD;
        result_src  = RES_ALURESULT;
        w_ir_write  = mem_ready;
        w_pc_update = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = RES_MEMDATA;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        fun7_en   = 1'b1;
      end
      S_EXECI: begin
        // instr[30] is part of the immediate here, so addi must never decode as sub.
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src  = RES_ALUOUT;
        w_reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        w_branch   = 1'b1;
      end
      S_JAL: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_FOUR;
        alu_op      = ALUOP_ADD;
        result_src  = RES_ALUOUT;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_write  = ~reset & (w_pc_update | (w_branch & zero));
  assign ir_write  = ~reset & w_ir_write;
  assign reg_write = ~reset & w_reg_write;
  assign mem_write = ~reset & w_mem_write;
  assign illegal   = r_illegal;
  assign instret   = r_instret;

endmodule

// File: tb/tb_main_control_fsm.sv
module tb_main_control_fsm;
  localparam int CNT_W = 4;   // small so the counter wrap is reachable

  localparam logic [6:0] L_LW = 7'b0000011, L_SW = 7'b0100011, L_R = 7'b0110011,
                         L_I = 7'b0010011, L_BEQ = 7'b1100011, L_JAL = 7'b1101111,
                         L_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [6:0] opcode;
  logic pc_write, ir_write, reg_write, mem_write, adr_src, fun7_en, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [CNT_W-1:0] instret;

  main_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_write(mem_write), .adr_src(adr_src), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .fun7_en(fun7_en), .imm_src(imm_src), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [CNT_W-1:0] ref_instret = '0;
  bit ref_ill = 1'b0;
  int zsel = 2;   // 0/1 force zero, 2 random

  function automatic logic [1:0] ref_imm(input logic [6:0] op);
    if (op == L_SW)  return 2'b01;
    if (op == L_BEQ) return 2'b10;
    if (op == L_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Expected control word for one cycle of a named instruction phase.
  function automatic logic [17:0] ref_ctrl(input string ph, input bit mr, input bit z,
                                           input logic [6:0] op, input bit ill);
    logic pcw, irw, rw, mw, adr, f7;
    logic [1:0] res, a, b, aop;
    {pcw, irw, rw, mw, adr, f7} = '0;
    {res, a, b, aop} = '0;
    case (ph)
      "F":   begin b = 2'b10; res = 2'b10; pcw = mr; irw = mr; end
      "D":   begin a = 2'b01; b = 2'b01; end
      "MA":  begin a = 2'b10; b = 2'b01; end
      "MR":  adr = 1'b1;
      "MWB": begin res = 2'b01; rw = 1'b1; end
      "MW":  begin adr = 1'b1; mw = 1'b1; end
      "XR":  begin a = 2'b10; aop = 2'b10; f7 = 1'b1; end
      "XI":  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      "WB":  rw = 1'b1;
      "BQ":  begin a = 2'b10; aop = 2'b01; pcw = z; end
      "J":   begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    return {pcw, irw, rw, mw, adr, res, a, b, aop, f7, ref_imm(op), ill};
  endfunction

  // One clock cycle in phase ph. mrsel: 0/1 drive mem_ready, 2 random.
  task automatic step(input string ph, input int mrsel);
    logic [17:0] got, exp;
    mem_ready = (mrsel == 2) ? 1'($urandom) : 1'(mrsel);
    zero      = (zsel == 2) ? 1'($urandom) : 1'(zsel);
    @(negedge clk);
    exp = ref_ctrl(ph, mem_ready, zero, opcode, ref_ill);
    got = {pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
           alu_src_a, alu_src_b, alu_op, fun7_en, imm_src, illegal};
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL ctrl[%s op=%b]: got %h expected %h", ph, opcode, got, exp);
    end
    n_tests++;
    assert (instret === ref_instret) else begin
      n_fail++;
      $error("FAIL instret[%s]: got %0d expected %0d", ph, instret, ref_instret);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int fst, input int mst);
    opcode = op;
    repeat (fst) step("F", 0);
    step("F", 1);
    step("D", 2);
    case (op)
      L_R:   begin step("XR", 2); step("WB", 2); end
      L_I:   begin step("XI", 2); step("WB", 2); end
      L_LW:  begin step("MA", 2); repeat (mst) step("MR", 0); step("MR", 1); step("MWB", 2); end
      L_SW:  begin step("MA", 2); repeat (mst) step("MW", 0); step("MW", 1); end
      L_BEQ: step("BQ", 2);
      L_JAL: begin step("J", 2); step("WB", 2); end
      default: ;
    endcase
    ref_instret = ref_instret + 1'b1;
  endtask

  task automatic rand_instr();
    logic [6:0] ops [6];
    ops = '{L_LW, L_SW, L_R, L_I, L_BEQ, L_JAL};
    run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  // One reset cycle with mem_ready high; every write enable must stay low.
  task automatic do_reset();
    logic [3:0] en;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b1;
    @(negedge clk);
    en = {pc_write, ir_write, reg_write, mem_write};
    n_tests++;
    assert (en === 4'b0) else begin
      n_fail++;
      $error("FAIL reset_enables: got %b expected 0000", en);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ref_instret = '0;
    ref_ill = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = L_R;
    @(posedge clk); #1;
    do_reset();

    // directed: add, addi, lw with 3-cycle stall, sw with 2-cycle stall
    run_instr(L_R, 0, 0);
    run_instr(L_I, 0, 0);
    run_instr(L_LW, 1, 3);
    run_instr(L_SW, 0, 2);
    // beq taken / not taken
    zsel = 1; run_instr(L_BEQ, 0, 0);
    zsel = 0; run_instr(L_BEQ, 0, 0);
    zsel = 2;
    run_instr(L_JAL, 0, 0);

    // reset in the middle of a stalled lw
    opcode = L_LW;
    step("F", 1); step("D", 2); step("MA", 2); step("MR", 0);
    do_reset();
    step("F", 0);
    // reset in the middle of a stalled sw: mem_write must not leak
    run_instr(L_R, 0, 0);
    opcode = L_SW;
    step("F", 1); step("D", 2); step("MA", 2); step("MW", 0);
    do_reset();

    // 15 random instructions, then a jal retires 15 -> 0
    repeat (15) rand_instr();
    run_instr(L_JAL, 1, 0);
    step("F", 0);
    repeat (40) rand_instr();

    // unknown opcode: absorbing ILLEGAL, sticky flag, no enables
    opcode = L_BAD;
    step("F", 1); step("D", 2);
    ref_ill = 1'b1;
    repeat (4) step("IL", 2);
    do_reset();
    run_instr(L_I, 0, 0);
    step("F", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
